// File: rtl/master_1_if.sv
// Valid/ready link between master_1 and its downstream receiver.
// The master drives valid/data; the receiver drives ready.
interface master_1_if;
    logic        valid;
    logic [31:0] data;
    logic        ready;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/master_1.sv
// Transmit end of the valid/ready link: write port, small FIFO,
// output register, overflow flag and transfer counter.
module master_1 #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [31:0]              wr_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    master_1_if.master               bus,
    output logic [CNT_W-1:0]         sent_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [31:0]      mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             valid_q, valid_d;
    logic [31:0]      data_q, data_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push, pop, hs;

    // full comes from registered level only, so a same-cycle pop
    // never rescues a write that arrives while full.
    always_comb begin
        full = (level_q == LVL_FULL);
        push = wr_en && !full;
        pop  = (level_q != '0) && (!valid_q || bus.ready);
        hs   = valid_q && bus.ready;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        valid_d  = valid_q;
        data_d   = data_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + ONE;
        end
        if (wr_en && full) begin
            ovf_d = 1'b1;
        end

        unique case ({push, pop})
            2'b10:   level_d = level_q + ONE;
            2'b01:   level_d = level_q - ONE;
            default: level_d = level_q;
        endcase

        if (hs) begin
            cnt_d = cnt_q + CNT_ONE;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + ONE;
            valid_d  = 1'b1;
            data_d   = mem_q[rd_ptr_q[AW-1:0]];
        end else if (hs) begin
            valid_d = 1'b0;
            data_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset; pointers and level define what is live.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    assign level     = level_q;
    assign overflow  = ovf_q;
    assign sent_cnt  = cnt_q;
    assign bus.valid = valid_q;
    assign bus.data  = data_q;

endmodule

// File: doc/master_1.md
# master_1

Source (transmitter) end of the team's valid/ready handshake link. It accepts 32-bit words from a local write port and buffers them in a small FIFO. It presents them one at a time on `valid`/`data` to a downstream receiver, holding each word stable until the receiver's `ready` is sampled high. It also reports buffer level, a sticky overflow flag and a count of completed transfers.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; power of two, ≥2. Total capacity is DEPTH+1 words, counting the output register.
- `CNT_W`, default 16: width of `sent_cnt`.

Ports:
- `clk`  input  1: single clock; all logic on the rising edge.
- `rst_n`  input  1: reset, synchronous, active-low.
- `wr_en`  input  1: write strobe for `wr_data`.
- `wr_data`  input  32: word to enqueue.
- `full`  output  1: FIFO holds DEPTH words; a write this cycle is dropped.
- `level`  output  clog2(DEPTH)+1: FIFO occupancy, excluding the output register.
- `overflow`  output  1: sticky; set when a write is dropped.
- `valid`  output  1: `data` carries a word for the receiver.
- `data`  output  32: word offered to the receiver; 0 whenever `valid`=0.
- `ready`  input  1: receiver accepts `data` at the next rising edge.
- `sent_cnt`  output  CNT_W: number of completed handshakes, modulo 2^CNT_W.

## Operation
- **Write side.** At a rising edge with `wr_en`=1 and `full`=0, `wr_data` is written at the write pointer and `level` increments.
- **Dropped writes.** A write while `full`=1 is dropped and sets `overflow`. This holds even when a pop occurs in the same cycle, because `full` is decoded from registered `level` only.
- **Pointers.** Read and write pointers are clog2(DEPTH)+1 bits wide and wrap naturally. Full and empty are decided by `level`.
- **Output register.** It loads when `level`≠0 and (`valid`=0 or `ready`=1). On load it pops the FIFO head into `data` and sets `valid`=1.
- **Back-to-back transfers.** A handshake and a load in the same edge give back-to-back transfers with no bubble.
- **Handshake.** A transfer completes at a rising edge where `valid`=1 and `ready`=1. At that edge `sent_cnt` increments, wrapping from all-ones to 0.
- **Idle after transfer.** If no word is available at a handshake edge, `valid`→0 and `data`→0 at that edge.
- **Stability rule.**
  - Once `valid`=1, `valid` and `data` do not change until a handshake edge.
  - `valid` never depends combinationally on `ready`.
  - `ready` is never required before `valid`.
- **Simultaneous write and pop.** Both take effect and `level` is unchanged, provided `full`=0.
- **Write path.** A write into an empty FIFO with the output register idle still passes through the FIFO; there is no bypass.
- **Overflow.** `overflow` is cleared only by reset.

## Timing
- **Reset value at the first edge with `rst_n`=0.** `valid`=0, `data`=0, `full`=0, `level`=0, `overflow`=0, `sent_cnt`=0, pointers 0.
- **Reset mid-operation.** Any buffered words and the word on `data` are discarded at the reset edge. No handshake is counted at that edge, even if `ready`=1.
- **Latency.** A write accepted at edge k gives `valid`=1 after edge k+1, when the FIFO and output register were empty. The earliest handshake is edge k+2.
- **Throughput.** One word per cycle while the FIFO is non-empty and `ready`=1.
- **Status timing.** `full` and `level` are registered-state decodes and are valid throughout the cycle after the update edge.
- **Ready sampling.** `ready` is sampled only at rising edges. A receiver that changes `ready` on the falling edge is supported with no additional constraint.

## Test plan
- **Reset values.** Hold `rst_n`=0 for 3 cycles with `wr_en`=1 and `ready`=1 → all outputs 0 and no write accepted. Then release.
- **Single word.** Write 0xA5A5_0001 at edge 1 with `ready`=1 → `valid`=1 and `data`=0xA5A5_0001 after edge 2. The handshake occurs at edge 3, after which `valid`=0, `data`=0 and `sent_cnt`=1.
- **Backpressure.** Write 0x11, 0x22, 0x33 on consecutive edges, hold `ready`=0 for 6 cycles, then set it to 1.
  - While stalled: `valid`=1 and `data`=0x11 stable throughout, `level`=2.
  - After `ready`=1: 0x11, 0x22, 0x33 are delivered on 3 consecutive edges, then `valid`=0 and `sent_cnt`=3.
- **Full/overflow (DEPTH=4).** Hold `ready`=0 and write 0x1 through 0x6 on consecutive edges.
  - After the 5th write: `full`=1, `level`=4.
  - 6th write: dropped, `overflow`=1.
  - Then set `ready`=1 → exactly 0x1 through 0x5 are delivered in order, `full`=0, `level`=0, `overflow` stays 1.
- **Counter wrap.** Stream 65537 words with `ready`=1 → `sent_cnt`=1 at the end, and no word is lost or reordered (the scoreboard matches every word).
- **Reset mid-transfer.** Enqueue 3 words with `ready`=0, then pulse `rst_n`=0 for one edge with `ready`=1.
  - After the reset edge: `valid`=0, `level`=0, `sent_cnt`=0.
  - Set `ready`=1 and write 0x77 → exactly one word, 0x77, is delivered and `sent_cnt`=1.
